pmem_wb_buffer: RTL and testbench



---
 rtl/lc3b_ctypes.sv | 27 ++
 rtl/wb_entry_reg.sv | 31 +++
 rtl/pmem_wb_buffer.sv | 118 +++++++++++
 tb/tb_pmem_wb_buffer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_ctypes.sv
// Shared types for the LC-3b cache/memory slice: line-sized data, line
// addresses, the write-back buffer state encoding and address helpers.
package lc3b_ctypes;

  typedef logic [127:0] lc3b_cline;
  typedef logic [11:0]  lc3b_line_addr;
  typedef logic [15:0]  lc3b_word;

  typedef enum logic [2:0] {
    S_EMPTY,
    S_FULL,
    S_DRAIN,
    S_READ,
    S_RESP
  } wb_state_e;

  // Line number of a byte address; the 4-bit offset within the line is dropped.
  function automatic lc3b_line_addr line_of(input lc3b_word addr);
    return addr[15:4];
  endfunction

  // Line-aligned byte address for a line number.
  function automatic lc3b_word line_base(input lc3b_line_addr la);
    return {la, 4'h0};
  endfunction

endpackage

// File: rtl/wb_entry_reg.sv
// Single write-back buffer entry: valid flag, line address and line data.
// Load captures a new line and marks it valid; clear only drops the valid
// flag, the stale address/data stay visible on the memory-side buses.
module wb_entry_reg import lc3b_ctypes::*; (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          load,
  input  logic          clear,
  input  lc3b_line_addr load_addr,
  input  lc3b_cline     load_data,
  output logic          valid,
  output lc3b_line_addr addr,
  output lc3b_cline     data
);

  // Entry storage; load wins over clear if both were ever raised together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid <= 1'b0;
      addr  <= '0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      addr  <= load_addr;
      data  <= load_data;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pmem_wb_buffer.sv
// One-line write-back buffer between the cache and physical memory.
// A cache write is acknowledged as soon as it is buffered and drained to
// memory afterwards; cache reads go to memory once the buffer is empty.
// Build option: define WB_READ_FORWARD_EN to let a read that hits the
// buffered line be served from the buffer while it waits in S_FULL.
module pmem_wb_buffer import lc3b_ctypes::*; (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [15:0]   mem_address,
  input  logic [127:0]  mem_wdata,
  output logic [127:0]  mem_rdata,
  input  logic          mem_read,
  input  logic          mem_write,
  output logic          mem_resp,
  output logic [15:0]   pmem_address,
  output logic [127:0]  pmem_wdata,
  input  logic [127:0]  pmem_rdata,
  output logic          pmem_read,
  output logic          pmem_write,
  input  logic          pmem_resp
);

`ifdef WB_READ_FORWARD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  wb_state_e     state;
  logic          entry_valid;
  lc3b_line_addr entry_addr;
  lc3b_cline     entry_data;
  logic          entry_load;
  logic          entry_clear;
  logic          addr_hit;

  // Only the line number takes part in the match; byte offset is ignored.
  assign addr_hit    = entry_valid && (line_of(mem_address) == entry_addr);
  assign entry_load  = (state == S_EMPTY) && mem_write;
  assign entry_clear = (state == S_DRAIN) && pmem_resp;

  wb_entry_reg u_entry (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (entry_load),
    .clear     (entry_clear),
    .load_addr (line_of(mem_address)),
    .load_data (mem_wdata),
    .valid     (entry_valid),
    .addr      (entry_addr),
    .data      (entry_data)
  );

  // Memory address follows the pending read during S_READ, else the buffered line.
  always_comb begin
    pmem_address = line_base(entry_addr);
    if (state == S_READ) pmem_address = line_base(line_of(mem_address));
  end

  assign pmem_wdata = entry_data;

  // Buffer FSM; strobes are registered together with the state they belong to.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_EMPTY;
      mem_rdata  <= '0;
      mem_resp   <= 1'b0;
      pmem_read  <= 1'b0;
      pmem_write <= 1'b0;
    end else begin
      mem_resp <= 1'b0;
      case (state)
        S_EMPTY: begin
          if (mem_write) begin
            state    <= S_RESP;
            mem_resp <= 1'b1;
          end else if (mem_read) begin
            state     <= S_READ;
            pmem_read <= 1'b1;
          end
        end
        S_FULL: begin
          if (FWD_EN && mem_read && addr_hit) begin
            mem_rdata <= entry_data;
            state     <= S_RESP;
            mem_resp  <= 1'b1;
          end else begin
            state      <= S_DRAIN;
            pmem_write <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (pmem_resp) begin
            state      <= S_EMPTY;
            pmem_write <= 1'b0;
          end
        end
        S_READ: begin
          if (pmem_resp) begin
            mem_rdata <= pmem_rdata;
            pmem_read <= 1'b0;
            state     <= S_RESP;
            mem_resp  <= 1'b1;
          end
        end
        S_RESP: begin
          state <= entry_valid ? S_FULL : S_EMPTY;
        end
        default: begin
          state      <= S_EMPTY;
          pmem_read  <= 1'b0;
          pmem_write <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pmem_wb_buffer.sv
// Bench for pmem_wb_buffer: a cache-side request task, a behavioural memory
// with fixed latency, and queues of expected memory transactions and read data.
module tb_pmem_wb_buffer;
  import lc3b_ctypes::*;

  localparam int MEM_LAT = 3;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [15:0]  mem_address;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_read;
  logic         mem_write;
  logic         mem_resp;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_read;
  logic         pmem_write;
  logic         pmem_resp;

  pmem_wb_buffer dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .mem_address  (mem_address),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_resp     (mem_resp),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_resp    (pmem_resp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]  addr;
    logic [127:0] data;
  } wr_t;

  wr_t          exp_wr_q[$];
  logic [15:0]  exp_rd_q[$];
  logic [127:0] exp_rdata_q[$];
  logic [127:0] mem_img [logic [15:0]];

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_presp_cyc = 0;
  int rd_cycles = 0;
  bit mem_auto = 1'b1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Protocol monitor: read and write strobes must be exclusive.
  always @(negedge clk) begin
    if (reset_n && (pmem_read || pmem_write))
      chk("rw_excl", {127'd0, pmem_read && pmem_write}, 128'd0);
    if (pmem_read) rd_cycles++;
  end

  // Memory model: answers any strobe MEM_LAT cycles after it rises.
  initial begin
    int  busy;
    wr_t e;
    busy = 0;
    pmem_resp = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (mem_auto) begin
        pmem_resp = 1'b0;
        if (pmem_read || pmem_write) begin
          busy++;
          if (busy == MEM_LAT) begin
            busy = 0;
            pmem_resp = 1'b1;
            last_presp_cyc = cyc;
            if (pmem_write) begin
              mem_img[pmem_address] = pmem_wdata;
              if (exp_wr_q.size() == 0) chk("wr_unexpected", 128'd1, 128'd0);
              else begin
                e = exp_wr_q.pop_front();
                chk("wr_addr", {112'd0, pmem_address}, {112'd0, e.addr});
                chk("wr_data", pmem_wdata, e.data);
              end
            end else begin
              pmem_rdata = mem_img.exists(pmem_address) ? mem_img[pmem_address] : '0;
              chk("rd_after_drain", exp_wr_q.size(), 128'd0);
              if (exp_rd_q.size() == 0) chk("rd_unexpected", 128'd1, 128'd0);
              else chk("rd_addr", {112'd0, pmem_address}, {112'd0, exp_rd_q.pop_front()});
            end
          end
        end else begin
          busy = 0;
        end
      end else begin
        busy = 0;
      end
    end
  end

  // Cache-side request; holds until mem_resp and checks read data on return.
  task automatic cache_req(input logic rd, input logic wr, input logic [15:0] a,
                           input logic [127:0] wd, output int lat, output int resp_cyc);
    mem_read = rd; mem_write = wr; mem_address = a; mem_wdata = wd;
    lat = 0; resp_cyc = -1;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      lat++;
      if (mem_resp) begin
        resp_cyc = cyc;
        break;
      end
    end
    mem_read = 1'b0; mem_write = 1'b0;
    if (resp_cyc < 0) chk("req_timeout", 128'd0, 128'd1);
    else if (rd && !wr) begin
      if (exp_rdata_q.size() == 0) chk("rdata_unexpected", 128'd1, 128'd0);
      else chk("mem_rdata", mem_rdata, exp_rdata_q.pop_front());
    end
  endtask

  task automatic wait_drained(input string tag);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (dut.state == S_EMPTY && exp_wr_q.size() == 0 && !pmem_write) begin
        done = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    chk(tag, {127'd0, done}, 128'd1);
  endtask

  task automatic wait_pmem_write(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (pmem_write) begin
        seen = 1'b1;
        break;
      end
    end
    chk(tag, {127'd0, seen}, 128'd1);
  endtask

  initial begin
    int lat, rc, rd0;
    logic [127:0] a5, f0, d1, d2, d3;
    a5 = {16{8'hA5}}; f0 = {16{8'h0F}};
    d1 = {4{32'h2000_1111}}; d2 = {4{32'h3000_2222}}; d3 = {16{8'h33}};
    mem_img[16'h4560] = f0;

    reset_n = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0; mem_address = '0; mem_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_resp",   {127'd0, mem_resp},   128'd0);
    chk("rst_pmem_read",  {127'd0, pmem_read},  128'd0);
    chk("rst_pmem_write", {127'd0, pmem_write}, 128'd0);
    chk("rst_mem_rdata",  mem_rdata, 128'd0);
    chk("rst_pmem_addr",  {112'd0, pmem_address}, 128'd0);
    chk("rst_pmem_wdata", pmem_wdata, 128'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Write into empty buffer, then drain
    exp_wr_q.push_back('{16'h1230, a5});
    cache_req(1'b0, 1'b1, 16'h1230, a5, lat, rc);
    chk("wr_lat", lat, 128'd1);
    @(posedge clk); #1;
    chk("full_no_write",  {127'd0, pmem_write}, 128'd0);
    chk("full_resp_once", {127'd0, mem_resp},   128'd0);
    chk("full_addr",      {112'd0, pmem_address}, 128'h1230);
    chk("full_wdata",     pmem_wdata, a5);
    @(posedge clk); #1;
    chk("drain_write", {127'd0, pmem_write}, 128'd1);
    wait_drained("drain1_done");

    // Missed read from empty buffer
    exp_rd_q.push_back(16'h4560);
    exp_rdata_q.push_back(f0);
    cache_req(1'b1, 1'b0, 16'h4560, '0, lat, rc);
    chk("rd_resp_lat", rc - last_presp_cyc, 128'd1);
    @(posedge clk); #1;
    chk("rd_resp_once", {127'd0, mem_resp}, 128'd0);
    wait_drained("rd_idle");

    // Read hitting the buffered line with a different offset
    exp_wr_q.push_back('{16'h1230, a5});
    cache_req(1'b0, 1'b1, 16'h1230, a5, lat, rc);
    rd0 = rd_cycles;
    exp_rdata_q.push_back(a5);
`ifdef WB_READ_FORWARD_EN
    cache_req(1'b1, 1'b0, 16'h1238, '0, lat, rc);
    chk("fwd_lat", lat, 128'd2);
    chk("fwd_no_pmem_read", rd_cycles - rd0, 128'd0);
`else
    exp_rd_q.push_back(16'h1230);
    cache_req(1'b1, 1'b0, 16'h1238, '0, lat, rc);
    chk("nofwd_resp_lat", rc - last_presp_cyc, 128'd1);
    chk("nofwd_pmem_read", {127'd0, (rd_cycles - rd0) > 0}, 128'd1);
`endif
    wait_drained("hit_idle");

    // Second write arrives during drain of the first
    exp_wr_q.push_back('{16'h2000, d1});
    cache_req(1'b0, 1'b1, 16'h2000, d1, lat, rc);
    wait_pmem_write("wr2000_drain");
    exp_wr_q.push_back('{16'h3000, d2});
    cache_req(1'b0, 1'b1, 16'h3000, d2, lat, rc);
    chk("wr2_after_drain", rc - last_presp_cyc, 128'd2);
    wait_drained("back2back_idle");

    // Reset in the middle of a drain, then a stale pmem_resp
    mem_auto = 1'b0;
    cache_req(1'b0, 1'b1, 16'h7770, d3, lat, rc);
    wait_pmem_write("rst_drain_start");
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    chk("rst_drain_write", {127'd0, pmem_write}, 128'd0);
    chk("rst_drain_valid", {127'd0, dut.entry_valid}, 128'd0);
    chk("rst_drain_state", {125'd0, dut.state}, {125'd0, S_EMPTY});
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #2;
    pmem_resp = 1'b1;
    @(posedge clk); #2;
    pmem_resp = 1'b0;
    @(posedge clk); #1;
    chk("late_resp_state", {125'd0, dut.state}, {125'd0, S_EMPTY});
    chk("late_resp_write", {127'd0, pmem_write}, 128'd0);
    chk("late_resp_read",  {127'd0, pmem_read},  128'd0);
    chk("late_resp_mresp", {127'd0, mem_resp},   128'd0);
    mem_auto = 1'b1;

    // Simultaneous read and write while empty: write wins
    rd0 = rd_cycles;
    exp_wr_q.push_back('{16'h5550, d3});
    cache_req(1'b1, 1'b1, 16'h5550, d3, lat, rc);
    chk("both_lat", lat, 128'd1);
    chk("both_valid", {127'd0, dut.entry_valid}, 128'd1);
    chk("both_addr", {116'd0, dut.entry_addr}, 128'h555);
    wait_drained("both_idle");
    chk("both_no_read", rd_cycles - rd0, 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
